// File: rtl/vid_pixel_fifo.sv
// Pixel word FIFO between the bus fetch engine and the pixel output stage.
// Holds off popping until primed, then pops one word per active pixel.
module vid_pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int LOWATER = 8,
  parameter int PRIME   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  input  logic                   pix_ce,
  input  logic                   hblank,
  input  logic                   vblank,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   fetch_req,
  output logic [7:0]             R,
  output logic [7:0]             G,
  output logic [7:0]             B,
  output logic                   underflow,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] LOWATER_L = LW'(LOWATER);
  localparam logic [LW-1:0] PRIME_L   = LW'(PRIME);

  typedef enum logic {S_PRIME, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          unf_q, unf_d, ovf_q, ovf_d;
  logic [23:0]   mem_q [DEPTH];
  logic          wr_ok, active, pop;
  logic          unused_hi;

  assign unused_hi = ^wr_data[31:24];

  assign full      = (level_q == DEPTH_L);
  assign level     = level_q;
  assign fetch_req = (level_q <= LOWATER_L) && !flush;
  assign R         = rgb_q[23:16];
  assign G         = rgb_q[15:8];
  assign B         = rgb_q[7:0];
  assign underflow = unf_q;
  assign overflow  = ovf_q;

  // full is taken from the registered level, so a same-cycle pop never frees room
  assign wr_ok  = wr_en && !full && !flush;
  assign active = (state_q == S_RUN) && pix_ce && !hblank && !vblank;
  assign pop    = active && (level_q != '0) && !flush;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    rgb_d   = rgb_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    if (flush) begin
      state_d = S_PRIME;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      rgb_d   = '0;
      unf_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      wptr_d  = wptr_q + AW'(wr_ok);
      rptr_d  = rptr_q + AW'(pop);
      level_d = level_q + LW'(wr_ok) - LW'(pop);
      if (wr_en && full)
        ovf_d = 1'b1;
      if (active && level_q == '0)
        unf_d = 1'b1;
      if (state_q == S_PRIME)
        rgb_d = '0;
      else if (pix_ce)
        rgb_d = pop ? mem_q[rptr_q] : 24'h0;
      // priming looks at the level including this cycle's write
      if (state_q == S_PRIME && (level_d >= PRIME_L || level_d == DEPTH_L))
        state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_PRIME;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rgb_q   <= '0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rgb_q   <= rgb_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
    end
  end

  // storage needs no reset: level gates every read
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[wptr_q] <= wr_data[23:0];
  end
endmodule

// File: tb/tb_vid_pixel_fifo.sv
// Scoreboarded bench for vid_pixel_fifo: queue-based reference model feeds
// expectations, a monitor compares them after every clock edge.
module tb_vid_pixel_fifo;
  localparam int DEPTH   = 16;
  localparam int LOWATER = 8;
  localparam int PRIME   = 12;

  logic        clk = 1'b0;
  logic        reset, flush, wr_en, pix_ce, hblank, vblank;
  logic [31:0] wr_data;
  logic        full, fetch_req, underflow, overflow;
  logic [4:0]  level;
  logic [7:0]  R, G, B;

  typedef struct packed {
    logic [23:0] rgb;
    logic [4:0]  level;
    logic        unf;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  bit          primed, m_ovf, m_unf;
  logic [23:0] m_rgb;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  vid_pixel_fifo #(.DEPTH(DEPTH), .LOWATER(LOWATER), .PRIME(PRIME)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank), .full(full), .level(level),
    .fetch_req(fetch_req), .R(R), .G(G), .B(B), .underflow(underflow),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rgb", {R, G, B}, 32'(e.rgb));
      chk("level", 32'(level), 32'(e.level));
      chk("full", 32'(full), 32'(e.level == 5'(DEPTH)));
      chk("underflow", 32'(underflow), 32'(e.unf));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("fetch_req", 32'(fetch_req), 32'((e.level <= 5'(LOWATER)) && !flush));
    end
  end

  function automatic void model_clear();
    mq.delete();
    primed = 0;
    m_rgb  = '0;
    m_ovf  = 0;
    m_unf  = 0;
  endfunction

  // Apply one cycle of inputs (called at a negedge), update the model, queue result.
  task automatic step(input bit fl, input bit we, input logic [31:0] d,
                      input bit pc, input bit hb, input bit vb);
    bit          act, popd;
    int          sz;
    logic [31:0] w;
    flush = fl; wr_en = we; wr_data = d; pix_ce = pc; hblank = hb; vblank = vb;
    if (fl) begin
      model_clear();
    end else begin
      sz   = mq.size();
      act  = primed && pc && !hb && !vb;
      popd = act && sz > 0;
      w    = '0;
      if (popd) w = mq.pop_front();
      if (we) begin
        if (sz == DEPTH) m_ovf = 1;
        else mq.push_back(d);
      end
      if (act && sz == 0) m_unf = 1;
      if (!primed) m_rgb = '0;
      else if (pc) m_rgb = w[23:0];
      if (!primed && mq.size() >= PRIME) primed = 1;
    end
    sb.push_back('{m_rgb, 5'(mq.size()), m_unf, m_ovf});
    @(negedge clk);
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic mid_reset();
    #2;
    flush = 0; wr_en = 0; pix_ce = 0; hblank = 0; vblank = 0;
    reset = 1;
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_rgb", {R, G, B}, 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_fetch", 32'(fetch_req), 1);
    chk("rst_flags", {underflow, overflow}, 0);
    model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; flush = 0; wr_en = 0; wr_data = '0; pix_ce = 0; hblank = 0; vblank = 0;
    model_clear();
    #1;
    chk("por_level", 32'(level), 0);
    chk("por_rgb", {R, G, B}, 0);
    chk("por_fetch", 32'(fetch_req), 1);
    @(negedge clk); @(negedge clk);
    reset = 0;

    // prime with 12 words, no pixel enables
    for (int n = 0; n < 12; n++) begin
      step(0, 1, 32'h00112233 + n, 0, 0, 0);
      if (n == 7) chk("fetch_after_8", 32'(fetch_req), 1);
      if (n == 8) chk("fetch_after_9", 32'(fetch_req), 0);
    end
    chk("primed_level", 32'(level), 12);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("first_pix", {R, G, B}, 32'h112233 + i);
    end
    chk("after_3_pops", 32'(level), 9);

    // fill to full, then write alongside a pop
    for (int n = 12; n < 19; n++) step(0, 1, 32'h00112233 + n, 0, 0, 0);
    chk("full_level", 32'(level), 16);
    chk("full_flag", 32'(full), 1);
    step(0, 1, 32'hFFDEAD00, 1, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 15);
    chk("ovf_pix", {R, G, B}, 32'h112236);

    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, 0);
    chk("drained", 32'(level), 0);
    chk("drained_unf", 32'(underflow), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("unf_set", 32'(underflow), 1);
    chk("unf_rgb", {R, G, B}, 0);
    step(1, 1, 32'h00777777, 0, 0, 0);
    chk("flush_unf", 32'(underflow), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_level", 32'(level), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("flush_prime_nopop", {R, G, B, level}, 0);

    // blanking at level 5
    for (int n = 0; n < 12; n++) step(0, 1, 32'h00A00000 + n, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
    chk("pre_blank_rgb", {R, G, B}, 32'hA00007);
    step(0, 1, 32'h00B0B0B0, 0, 0, 0);
    chk("hold_rgb", {R, G, B}, 32'hA00007);
    chk("pre_blank_level", 32'(level), 5);
    step(0, 0, 0, 1, 1, 0);
    chk("hblank_level", 32'(level), 5);
    chk("hblank_rgb", {R, G, B}, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h00C0C0C0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    chk("vblank_level", 32'(level), 5);
    chk("vblank_rgb", {R, G, B}, 0);

    mid_reset();
    step(0, 1, 32'h00ABCDEF, 0, 0, 0);
    chk("first_edge_write", 32'(level), 1);

    // random traffic: wraps pointers many times
    for (int c = 0; c < 1500; c++) begin
      if (c % 500 == 250) mid_reset();
      step($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 55, $urandom,
           $urandom_range(0, 99) < 50, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0);
    end

    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
